// File: rtl/src_ctrl_pkg.sv
// src_ctrl_pkg: states, instruction classes, opcodes, ALU ops, bus selects and IR field positions for control_unit.
package src_ctrl_pkg;
  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_e;
  typedef enum logic [2:0] {CL_BINARY, CL_UNARY, CL_MULDIV, CL_HALT, CL_ILLEGAL} iclass_e;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_NEG  = 4'h2;
  localparam logic [3:0] ALU_NOT  = 4'h3;
  localparam logic [3:0] ALU_AND  = 4'h4;
  localparam logic [3:0] ALU_OR   = 4'h5;
  localparam logic [3:0] ALU_SHR  = 4'h6;
  localparam logic [3:0] ALU_SHRA = 4'h7;
  localparam logic [3:0] ALU_SHL  = 4'h8;
  localparam logic [3:0] ALU_ROR  = 4'h9;
  localparam logic [3:0] ALU_ROL  = 4'hA;
  localparam logic [3:0] ALU_MUL  = 4'hB;
  localparam logic [3:0] ALU_DIV  = 4'hC;
  localparam logic [3:0] ALU_INC  = 4'hD;
  localparam logic [4:0] SEL_HI  = 5'b10000;
  localparam logic [4:0] SEL_LO  = 5'b10001;
  localparam logic [4:0] SEL_ZHI = 5'b10010;
  localparam logic [4:0] SEL_ZLO = 5'b10011;
  localparam logic [4:0] SEL_PC  = 5'b10100;
  localparam logic [4:0] SEL_MDR = 5'b10101;
endpackage

// File: rtl/instr_decode.sv
// instr_decode: opcode to instruction class and ALU op; MUL/DIV decode only when CU_MULDIV_EN is defined.
module instr_decode
  import src_ctrl_pkg::*;
(
  input  logic [4:0] opcode_i,
  output logic [2:0] iclass_o,
  output logic [3:0] alu_op_o
);
  always_comb begin
    iclass_o = CL_ILLEGAL;
    alu_op_o = ALU_ADD;
    case (opcode_i)
      OP_ADD:  begin iclass_o = CL_BINARY; alu_op_o = ALU_ADD;  end
      OP_SUB:  begin iclass_o = CL_BINARY; alu_op_o = ALU_SUB;  end
      OP_AND:  begin iclass_o = CL_BINARY; alu_op_o = ALU_AND;  end
      OP_OR:   begin iclass_o = CL_BINARY; alu_op_o = ALU_OR;   end
      OP_ROR:  begin iclass_o = CL_BINARY; alu_op_o = ALU_ROR;  end
      OP_ROL:  begin iclass_o = CL_BINARY; alu_op_o = ALU_ROL;  end
      OP_SHR:  begin iclass_o = CL_BINARY; alu_op_o = ALU_SHR;  end
      OP_SHRA: begin iclass_o = CL_BINARY; alu_op_o = ALU_SHRA; end
      OP_SHL:  begin iclass_o = CL_BINARY; alu_op_o = ALU_SHL;  end
      OP_NEG:  begin iclass_o = CL_UNARY;  alu_op_o = ALU_NEG;  end
      OP_NOT:  begin iclass_o = CL_UNARY;  alu_op_o = ALU_NOT;  end
`ifdef CU_MULDIV_EN
      OP_MUL:  begin iclass_o = CL_MULDIV; alu_op_o = ALU_MUL;  end
      OP_DIV:  begin iclass_o = CL_MULDIV; alu_op_o = ALU_DIV;  end
`endif
      OP_HALT: iclass_o = CL_HALT;
      default: ;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: Mini SRC hardwired fetch/decode/execute sequencer.
// Define CU_MULDIV_EN to compile in MUL/DIV (state T6, e_HI/e_LO); otherwise those opcodes are illegal.
module control_unit
  import src_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        e_PC,
  output logic        e_IR,
  output logic        e_Y,
  output logic        e_Z,
  output logic        e_HI,
  output logic        e_LO,
  output logic        e_MDR,
  output logic        e_MAR,
  output logic        e_GP,
  output logic        incPC,
  output logic        MDR_read,
  output logic [4:0]  BusDataSelect,
  output logic [3:0]  GP_addr,
  output logic [3:0]  ALU_op,
  output logic        halted,
  output logic        illegal
);
  state_e state_q, state_d, done_st;
  logic ill_q, ill_d;
  logic [2:0] iclass;
  logic [3:0] dec_alu, ra, rb, rc;
  logic unused_ir;
  iclass_e cls;
  assign ra = ir[RA_MSB:RA_LSB];
  assign rb = ir[RB_MSB:RB_LSB];
  assign rc = ir[RC_MSB:RC_LSB];
  assign unused_ir = ^ir[RC_LSB-1:0];
  assign cls = iclass_e'(iclass);
  assign done_st = run ? T0 : IDLE;
  instr_decode u_dec (
    .opcode_i(ir[OPC_MSB:OPC_LSB]),
    .iclass_o(iclass),
    .alu_op_o(dec_alu)
  );
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ill_q   <= ill_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE: state_d = run ? T0 : IDLE;
      T0:   state_d = T1;
      T1:   state_d = mem_ready ? T2 : T1;
      T2: begin
        state_d = (cls == CL_BINARY || cls == CL_MULDIV) ? T3 : (cls == CL_UNARY) ? T4 : HALT;
        ill_d   = cls == CL_ILLEGAL;
      end
      T3:   state_d = T4;
      T4:   state_d = T5;
      T5:   state_d = (cls == CL_MULDIV) ? T6 : done_st;
`ifdef CU_MULDIV_EN
      T6:   state_d = done_st;
`endif
      default: ;
    endcase
  end
  // Every output is a pure decode of the current step; IDLE and aborted steps issue nothing.
  always_comb begin
    e_PC = 1'b0;
    e_IR = 1'b0;
    e_Y = 1'b0;
    e_Z = 1'b0;
    e_HI = 1'b0;
    e_LO = 1'b0;
    e_MDR = 1'b0;
    e_MAR = 1'b0;
    e_GP = 1'b0;
    incPC = 1'b0;
    MDR_read = 1'b0;
    BusDataSelect = 5'd0;
    GP_addr = 4'd0;
    ALU_op = ALU_ADD;
    halted = 1'b0;
    illegal = 1'b0;
    case (state_q)
      T0: begin
        BusDataSelect = SEL_PC;
        e_MAR = 1'b1;
        incPC = 1'b1;
        ALU_op = ALU_INC;
        e_Z = 1'b1;
      end
      T1: begin
        BusDataSelect = SEL_ZLO;
        e_PC = 1'b1;
        MDR_read = 1'b1;
        e_MDR = mem_ready;
      end
      T2: begin
        BusDataSelect = SEL_MDR;
        e_IR = 1'b1;
      end
      T3: begin
        BusDataSelect = {1'b0, (cls == CL_MULDIV) ? ra : rb};
        e_Y = 1'b1;
      end
      T4: begin
        BusDataSelect = {1'b0, (cls == CL_BINARY) ? rc : rb};
        ALU_op = dec_alu;
        e_Z = 1'b1;
      end
      T5: begin
        BusDataSelect = SEL_ZLO;
        e_LO = cls == CL_MULDIV;
        e_GP = cls != CL_MULDIV;
        GP_addr = (cls == CL_MULDIV) ? 4'd0 : ra;
      end
`ifdef CU_MULDIV_EN
      T6: begin
        BusDataSelect = SEL_ZHI;
        e_HI = 1'b1;
      end
`endif
      HALT: begin
        halted = 1'b1;
        illegal = ill_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized instruction streams checked cycle by cycle against a per-instruction expected trace.
module tb_control_unit;
  logic clock = 1'b0, clear = 1'b0, run = 1'b0, mem_ready = 1'b0;
  logic [31:0] ir = 32'd0;
  logic e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP, incPC, MDR_read, halted, illegal;
  logic [4:0] BusDataSelect;
  logic [3:0] GP_addr, ALU_op;
  logic [25:0] obs;
  int n_tests = 0, n_fail = 0;
  bit at_t0 = 1'b0;
`ifdef CU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam logic [25:0] F_PC = 26'd1 << 25, F_IR = 26'd1 << 24, F_Y = 26'd1 << 23, F_Z = 26'd1 << 22;
  localparam logic [25:0] F_HI = 26'd1 << 21, F_LO = 26'd1 << 20, F_MDR = 26'd1 << 19, F_MAR = 26'd1 << 18;
  localparam logic [25:0] F_GP = 26'd1 << 17, F_INC = 26'd1 << 16, F_MRD = 26'd1 << 15;
  localparam logic [25:0] F_HALT = 26'd2, F_ILL = 26'd1;
  localparam logic [4:0] S_ZHI = 5'd18, S_ZLO = 5'd19, S_PC = 5'd20, S_MDR = 5'd21;
  control_unit dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
    .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI), .e_LO(e_LO),
    .e_MDR(e_MDR), .e_MAR(e_MAR), .e_GP(e_GP), .incPC(incPC), .MDR_read(MDR_read),
    .BusDataSelect(BusDataSelect), .GP_addr(GP_addr), .ALU_op(ALU_op),
    .halted(halted), .illegal(illegal)
  );
  assign obs = {e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP, incPC, MDR_read,
                BusDataSelect, GP_addr, ALU_op, halted, illegal};
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [25:0] got, input logic [25:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s ir=%h: got %h expected %h", tag, ir, got, exp);
    end
  endtask
  function automatic logic [25:0] v(input logic [4:0] s, input logic [3:0] g, input logic [3:0] a);
    return {11'd0, s, g, a, 2'd0};
  endfunction
  // 0 binary, 1 unary, 2 mul/div, 3 halt, 4 illegal
  function automatic int cls_of(input logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd11) return 0;
    if (op == 5'd17 || op == 5'd18) return 1;
    if (MD && (op == 5'd15 || op == 5'd16)) return 2;
    if (op == 5'd27) return 3;
    return 4;
  endfunction
  function automatic logic [3:0] alu_of(input logic [4:0] op);
    logic [3:0] tbl [32];
    foreach (tbl[i]) tbl[i] = 4'h0;
    tbl[3] = 4'h0; tbl[4] = 4'h1; tbl[5] = 4'h4; tbl[6] = 4'h5; tbl[7] = 4'h9;
    tbl[8] = 4'hA; tbl[9] = 4'h6; tbl[10] = 4'h7; tbl[11] = 4'h8;
    tbl[17] = 4'h2; tbl[18] = 4'h3; tbl[16] = 4'hB; tbl[15] = 4'hC;
    return tbl[op];
  endfunction
  task automatic step(input logic [25:0] exp, input bit mr, input bit rn, input string tag);
    mem_ready = mr;
    run = rn;
    @(negedge clock);
    check(tag, obs, exp);
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    clear = 1'b1;
    #1;
    check("clear_async", obs, 26'd0);
    @(posedge clock);
    #1;
    clear = 1'b0;
    at_t0 = 1'b0;
  endtask
  task automatic go();
    if (!at_t0) begin
      repeat ($urandom_range(0, 2)) step(26'd0, 1'($urandom), 1'b0, "idle");
      step(26'd0, 1'($urandom), 1'b1, "idle_go");
      at_t0 = 1'b1;
    end
  endtask
  task automatic instr(input logic [31:0] w, input int waits, input bit last_run, input int abort_at);
    logic [25:0] q[$];
    bit mq[$];
    string tq[$];
    logic [3:0] ra, rb, rc, a;
    int c;
    ir = w;
    ra = w[26:23]; rb = w[22:19]; rc = w[18:15];
    c = cls_of(w[31:27]);
    a = alu_of(w[31:27]);
    q.push_back(v(S_PC, 4'd0, 4'hD) | F_MAR | F_INC | F_Z); mq.push_back(1'($urandom)); tq.push_back("T0");
    for (int i = 0; i < waits; i++) begin
      q.push_back(v(S_ZLO, 4'd0, 4'd0) | F_PC | F_MRD); mq.push_back(1'b0); tq.push_back("T1_wait");
    end
    q.push_back(v(S_ZLO, 4'd0, 4'd0) | F_PC | F_MRD | F_MDR); mq.push_back(1'b1); tq.push_back("T1_ready");
    q.push_back(v(S_MDR, 4'd0, 4'd0) | F_IR); mq.push_back(1'($urandom)); tq.push_back("T2");
    if (c == 0) begin
      q.push_back(v({1'b0, rb}, 4'd0, 4'd0) | F_Y); tq.push_back("T3_bin");
      q.push_back(v({1'b0, rc}, 4'd0, a) | F_Z); tq.push_back("T4_bin");
      q.push_back(v(S_ZLO, ra, 4'd0) | F_GP); tq.push_back("T5_bin");
    end else if (c == 1) begin
      q.push_back(v({1'b0, rb}, 4'd0, a) | F_Z); tq.push_back("T4_un");
      q.push_back(v(S_ZLO, ra, 4'd0) | F_GP); tq.push_back("T5_un");
    end else if (c == 2) begin
      q.push_back(v({1'b0, ra}, 4'd0, 4'd0) | F_Y); tq.push_back("T3_md");
      q.push_back(v({1'b0, rb}, 4'd0, a) | F_Z); tq.push_back("T4_md");
      q.push_back(v(S_ZLO, 4'd0, 4'd0) | F_LO); tq.push_back("T5_lo");
      q.push_back(v(S_ZHI, 4'd0, 4'd0) | F_HI); tq.push_back("T6_hi");
    end
    while (mq.size() < q.size()) mq.push_back(1'($urandom));
    for (int i = 0; i < q.size(); i++) begin
      if (i == abort_at) begin
        mem_ready = 1'($urandom);
        do_reset();
        return;
      end
      step(q[i], mq[i], (i == q.size() - 1) ? last_run : 1'($urandom), tq[i]);
    end
    if (c >= 3) begin
      repeat (3) step(F_HALT | ((c == 4) ? F_ILL : 26'd0), 1'($urandom), 1'($urandom), "halt_hold");
      do_reset();
    end else
      at_t0 = last_run;
  endtask
  initial begin
    logic [4:0] legal [14] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd17, 5'd18, 5'd15, 5'd16, 5'd27};
    logic [4:0] op;
    #1 clear = 1'b1;
    #1 check("reset", obs, 26'd0);
    @(posedge clock);
    #1;
    clear = 1'b0;
    step(26'd0, 1'b1, 1'b0, "idle_no_run");
    go(); instr(32'h19890000, 0, 1'b1, -1);
    instr(32'h8A800000, 0, 1'b1, -1);
    instr(32'h19890000, 3, 1'b0, -1);
    go(); instr(32'h83380000, 0, 1'b0, -1);
    go(); instr(32'hD8000000, 1, 1'b1, -1);
    go(); instr(32'h00000000, 0, 1'b1, -1);
    go(); instr(32'h19890000, 0, 1'b1, 4);
    go(); instr(32'h19890000, 2, 1'b1, 6);
    go(); instr(32'h19890000, 0, 1'b0, -1);
    for (int n = 0; n < 300; n++) begin
      go();
      op = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 13)] : 5'($urandom);
      instr({op, 27'($urandom)}, $urandom_range(0, 3), 1'($urandom),
            ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
